// File: rtl/calc_pkg.sv
// calc_seq shared definitions: opt codes,
// key kinds and the sequencer state enum.
package calc_pkg;

  localparam logic [2:0] OPT_ADD = 3'b000;
  localparam logic [2:0] OPT_SUB = 3'b001;
  localparam logic [2:0] OPT_MUL = 3'b010;
  localparam logic [2:0] OPT_DIV = 3'b011;
  localparam logic [2:0] OPT_CMP = 3'b101;

  localparam logic [1:0] KEY_OPERAND  = 2'b00;
  localparam logic [1:0] KEY_OPERATOR = 2'b01;
  localparam logic [1:0] KEY_EQUALS   = 2'b10;
  localparam logic [1:0] KEY_CLEAR    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HAVE_A,
    S_HAVE_OP,
    S_HAVE_B,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/calc_if.sv
// Key, ALU and display bundle around calc_seq.
// slave is the sequencer side, master the environment.
interface calc_if #(
  parameter int WIDTH = 16
);
  logic             key_valid;
  logic [1:0]       key_kind;
  logic [WIDTH-1:0] key_data;
  logic             key_ready;
  logic             alu_start;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       opt;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH-1:0] bin_data;
  logic             carry_flag;
  logic             result_valid;
  logic             err;

  modport slave (
    input  key_valid, key_kind, key_data,
    input  alu_done, alu_result, alu_carry,
    output key_ready, alu_start, alu_a, alu_b,
    output opt, bin_data, carry_flag,
    output result_valid, err
  );

  modport master (
    output key_valid, key_kind, key_data,
    output alu_done, alu_result, alu_carry,
    input  key_ready, alu_start, alu_a, alu_b,
    input  opt, bin_data, carry_flag,
    input  result_valid, err
  );
endinterface

// File: rtl/calc_watchdog.sv
// Loadable down-counter; expire fires when
// enabled at zero, TIMEOUT cycles after load.
module calc_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);
endmodule

// File: rtl/calc_seq.sv
// Calculator operation sequencer: collects A, op, B,
// launches the ALU and holds the result for display.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input logic   clk,
  input logic   rst_n,
  calc_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [WIDTH-1:0] bin_q, bin_n;
  logic [2:0]       opt_q, opt_n;
  logic             carry_q, carry_n;
  logic             err_q, err_n;
  logic             rv_q, rv_n;
  logic             start_q, start_n;
  logic             wd_load, wd_expire;
  logic             ready;
  logic             k_opd, k_opr, k_eq, k_clr;

  assign ready = (state != S_WAIT);

  assign k_clr = bus.key_valid
              && bus.key_kind == KEY_CLEAR;
  assign k_opd = bus.key_valid && ready
              && bus.key_kind == KEY_OPERAND;
  assign k_opr = bus.key_valid && ready
              && bus.key_kind == KEY_OPERATOR;
  assign k_eq  = bus.key_valid && ready
              && bus.key_kind == KEY_EQUALS;

  calc_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .clr    (k_clr),
    .en     (state == S_WAIT),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bin_q   <= '0;
      opt_q   <= OPT_ADD;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      bin_q   <= bin_n;
      opt_q   <= opt_n;
      carry_q <= carry_n;
      err_q   <= err_n;
      rv_q    <= rv_n;
      start_q <= start_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    bin_n   = bin_q;
    opt_n   = opt_q;
    carry_n = carry_q;
    err_n   = err_q;
    rv_n    = 1'b0;
    start_n = 1'b0;
    wd_load = 1'b0;
    if (k_clr) begin
      state_n = S_IDLE;
      a_n     = '0;
      b_n     = '0;
      bin_n   = '0;
      opt_n   = OPT_ADD;
      carry_n = 1'b0;
      err_n   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (k_opd) begin
            a_n     = bus.key_data;
            state_n = S_HAVE_A;
          end
        end
        S_HAVE_A: begin
          unique case (1'b1)
            k_opd: a_n = bus.key_data;
            k_opr: begin
              opt_n   = bus.key_data[2:0];
              state_n = S_HAVE_OP;
            end
            k_eq: begin
              bin_n   = a_q;
              carry_n = 1'b0;
              rv_n    = 1'b1;
              state_n = S_DONE;
            end
            default: ;
          endcase
        end
        S_HAVE_OP: begin
          unique case (1'b1)
            k_opd: begin
              b_n     = bus.key_data;
              state_n = S_HAVE_B;
            end
            k_opr: opt_n = bus.key_data[2:0];
            default: ;
          endcase
        end
        S_HAVE_B: begin
          unique case (1'b1)
            k_opd: b_n = bus.key_data;
            k_eq: begin
              if (opt_q == OPT_DIV && b_q == '0) begin
                err_n   = 1'b1;
                state_n = S_ERR;
              end else begin
                start_n = 1'b1;
                wd_load = 1'b1;
                state_n = S_WAIT;
              end
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          // a done strobe during the launch cycle is stale
          if (bus.alu_done && !start_q) begin
            bin_n   = bus.alu_result;
            carry_n = bus.alu_carry;
            rv_n    = 1'b1;
            state_n = S_DONE;
          end else if (wd_expire) begin
            err_n   = 1'b1;
            state_n = S_ERR;
          end
        end
        S_DONE: begin
          unique case (1'b1)
            k_opr: begin
              a_n     = bin_q;
              opt_n   = bus.key_data[2:0];
              state_n = S_HAVE_OP;
            end
            k_opd: begin
              a_n     = bus.key_data;
              state_n = S_HAVE_A;
            end
            k_eq: begin
              a_n     = bin_q;
              start_n = 1'b1;
              wd_load = 1'b1;
              state_n = S_WAIT;
            end
            default: ;
          endcase
        end
        S_ERR: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.key_ready    = ready;
  assign bus.alu_start    = start_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.opt          = opt_q;
  assign bus.bin_data     = bin_q;
  assign bus.carry_flag   = carry_q;
  assign bus.result_valid = rv_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a hand-driven
// ALU response and TIMEOUT=8.
module tb_calc_seq;
  import calc_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   starts;
  int   rvs;

  calc_if #(.WIDTH(16)) bus ();

  calc_seq #(.WIDTH(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.alu_start === 1'b1) starts++;
    if (bus.result_valid === 1'b1) rvs++;
  end

  task automatic key(input logic [1:0] kind,
                     input logic [15:0] data);
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.key_kind  = kind;
    bus.key_data  = data;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (bus.key_ready !== 1'b1 || bus.alu_start !== 1'b0
        || bus.result_valid !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: rdy=%b st=%b rv=%b err=%b want 1 0 0 0",
               bus.key_ready, bus.alu_start, bus.result_valid, bus.err);
    end
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.opt !== 3'b000
        || bus.bin_data !== 16'h0 || bus.carry_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h opt=%b bin=%h c=%b want zeros",
               bus.alu_a, bus.alu_b, bus.opt, bus.bin_data, bus.carry_flag);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    key(KEY_OPERAND, 16'd5);
    key(KEY_OPERATOR, 16'd0);
    key(KEY_OPERAND, 16'd3);
    key(KEY_EQUALS, 16'd0);
    checks++;
    if (bus.alu_start !== 1'b1 || bus.alu_a !== 16'd5
        || bus.alu_b !== 16'd3 || bus.opt !== 3'b000) begin
      errors++;
      $display("FAIL add_launch: st=%b a=%h b=%h opt=%b want 1 5 3 000",
               bus.alu_start, bus.alu_a, bus.alu_b, bus.opt);
    end
    checks++;
    if (bus.key_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_ready: got %b want 0", bus.key_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.alu_done = 1'b1; bus.alu_result = 16'd8; bus.alu_carry = 1'b0;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    checks++;
    if (bus.bin_data !== 16'd8 || bus.result_valid !== 1'b1
        || dut.state !== S_DONE || bus.carry_flag !== 1'b0) begin
      errors++;
      $display("FAIL add_result: bin=%h rv=%b st=%0d c=%b want 8 1 %0d 0",
               bus.bin_data, bus.result_valid, dut.state, bus.carry_flag,
               S_DONE);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.result_valid !== 1'b0 || starts != 1 || rvs != 1) begin
      errors++;
      $display("FAIL add_pulse: rv=%b starts=%0d rvs=%0d want 0 1 1",
               bus.result_valid, starts, rvs);
    end
  endtask

  task automatic test_chain();
    key(KEY_OPERATOR, 16'd1);
    key(KEY_OPERAND, 16'd10);
    key(KEY_EQUALS, 16'd0);
    checks++;
    if (bus.alu_start !== 1'b1 || bus.alu_a !== 16'd8
        || bus.alu_b !== 16'd10 || bus.opt !== 3'b001) begin
      errors++;
      $display("FAIL chain_launch: st=%b a=%h b=%h opt=%b want 1 8 a 001",
               bus.alu_start, bus.alu_a, bus.alu_b, bus.opt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.alu_start !== 1'b0) begin
      errors++;
      $display("FAIL chain_start_pulse: got %b want 0", bus.alu_start);
    end
    bus.alu_done = 1'b1; bus.alu_result = 16'hFFFE; bus.alu_carry = 1'b1;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    checks++;
    if (bus.bin_data !== 16'hFFFE || bus.carry_flag !== 1'b1
        || bus.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL chain_result: bin=%h c=%b rv=%b want fffe 1 1",
               bus.bin_data, bus.carry_flag, bus.result_valid);
    end
  endtask

  task automatic test_back_to_back();
    key(KEY_EQUALS, 16'd0);
    checks++;
    if (bus.alu_start !== 1'b1 || bus.alu_a !== 16'hFFFE
        || bus.alu_b !== 16'd10 || bus.opt !== 3'b001) begin
      errors++;
      $display("FAIL repeat_launch: st=%b a=%h b=%h opt=%b want 1 fffe a 001",
               bus.alu_start, bus.alu_a, bus.alu_b, bus.opt);
    end
    bus.alu_done = 1'b1; bus.alu_result = 16'h1234; bus.alu_carry = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dut.state !== S_WAIT || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_done: st=%0d rv=%b want %0d 0",
               dut.state, bus.result_valid, S_WAIT);
    end
    bus.alu_result = 16'hFFF4; bus.alu_carry = 1'b0;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    checks++;
    if (bus.bin_data !== 16'hFFF4 || bus.carry_flag !== 1'b0) begin
      errors++;
      $display("FAIL repeat_result: bin=%h c=%b want fff4 0",
               bus.bin_data, bus.carry_flag);
    end
    key(KEY_OPERAND, 16'd9);
    key(KEY_EQUALS, 16'd0);
    checks++;
    if (bus.bin_data !== 16'd9 || bus.result_valid !== 1'b1
        || bus.carry_flag !== 1'b0 || starts != 3) begin
      errors++;
      $display("FAIL a_equals: bin=%h rv=%b c=%b starts=%0d want 9 1 0 3",
               bus.bin_data, bus.result_valid, bus.carry_flag, starts);
    end
  endtask

  task automatic test_div_zero();
    key(KEY_OPERAND, 16'd7);
    key(KEY_OPERATOR, 16'd3);
    key(KEY_OPERAND, 16'd0);
    key(KEY_EQUALS, 16'd0);
    checks++;
    if (bus.alu_start !== 1'b0 || bus.err !== 1'b1
        || dut.state !== S_ERR || starts != 3) begin
      errors++;
      $display("FAIL div0: st=%b err=%b state=%0d starts=%0d want 0 1 %0d 3",
               bus.alu_start, bus.err, dut.state, starts, S_ERR);
    end
    key(KEY_OPERAND, 16'd4);
    key(KEY_EQUALS, 16'd0);
    checks++;
    if (dut.state !== S_ERR || bus.bin_data !== 16'd9
        || bus.alu_start !== 1'b0 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: state=%0d bin=%h st=%b err=%b want %0d 9 0 1",
               dut.state, bus.bin_data, bus.alu_start, bus.err, S_ERR);
    end
    key(KEY_CLEAR, 16'd0);
    checks++;
    if (bus.err !== 1'b0 || bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0
        || bus.opt !== 3'b000 || bus.bin_data !== 16'h0
        || bus.carry_flag !== 1'b0 || dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL clear: err=%b a=%h b=%h opt=%b bin=%h c=%b st=%0d want 0s",
               bus.err, bus.alu_a, bus.alu_b, bus.opt, bus.bin_data,
               bus.carry_flag, dut.state);
    end
  endtask

  task automatic test_timeout();
    key(KEY_OPERAND, 16'd2);
    key(KEY_OPERATOR, 16'd0);
    key(KEY_OPERAND, 16'd2);
    key(KEY_EQUALS, 16'd0);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b0 || dut.state !== S_WAIT) begin
      errors++;
      $display("FAIL timeout_early: err=%b st=%0d want 0 %0d",
               bus.err, dut.state, S_WAIT);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1 || dut.state !== S_ERR) begin
      errors++;
      $display("FAIL timeout: err=%b st=%0d want 1 %0d",
               bus.err, dut.state, S_ERR);
    end
    bus.alu_done = 1'b1; bus.alu_result = 16'h0055; bus.alu_carry = 1'b1;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.bin_data !== 16'h0 || bus.carry_flag !== 1'b0
        || rvs != 4 || dut.state !== S_ERR) begin
      errors++;
      $display("FAIL late_done: bin=%h c=%b rvs=%0d st=%0d want 0 0 4 %0d",
               bus.bin_data, bus.carry_flag, rvs, dut.state, S_ERR);
    end
    key(KEY_CLEAR, 16'd0);
  endtask

  task automatic test_clear_vs_done();
    key(KEY_OPERAND, 16'd1);
    key(KEY_OPERATOR, 16'd0);
    key(KEY_OPERAND, 16'd1);
    key(KEY_EQUALS, 16'd0);
    @(posedge clk); #1;
    bus.alu_done = 1'b1; bus.alu_result = 16'd2; bus.alu_carry = 1'b1;
    bus.key_valid = 1'b1; bus.key_kind = KEY_CLEAR; bus.key_data = 16'd0;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    bus.key_valid = 1'b0;
    checks++;
    if (dut.state !== S_IDLE || bus.bin_data !== 16'h0
        || bus.result_valid !== 1'b0 || bus.alu_a !== 16'h0
        || bus.carry_flag !== 1'b0) begin
      errors++;
      $display("FAIL clr_done: st=%0d bin=%h rv=%b a=%h c=%b want %0d 0 0 0 0",
               dut.state, bus.bin_data, bus.result_valid, bus.alu_a,
               bus.carry_flag, S_IDLE);
    end
    @(posedge clk); #1;
    checks++;
    if (rvs != 4 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_rv: rvs=%0d rv=%b want 4 0",
               rvs, bus.result_valid);
    end
  endtask

  task automatic test_async_reset();
    key(KEY_OPERAND, 16'd3);
    key(KEY_OPERATOR, 16'd2);
    key(KEY_OPERAND, 16'd4);
    key(KEY_EQUALS, 16'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.opt !== 3'b000
        || bus.key_ready !== 1'b1 || bus.alu_start !== 1'b0
        || dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL async_rst: a=%h b=%h opt=%b rdy=%b st=%b state=%0d want 0 0 0 1 0 %0d",
               bus.alu_a, bus.alu_b, bus.opt, bus.key_ready,
               bus.alu_start, dut.state, S_IDLE);
    end
    #3 rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    starts = 0;
    rvs    = 0;
    bus.key_valid  = 1'b0;
    bus.key_kind   = 2'b00;
    bus.key_data   = 16'h0;
    bus.alu_done   = 1'b0;
    bus.alu_result = 16'h0;
    bus.alu_carry  = 1'b0;
    test_reset();
    test_add();
    test_chain();
    test_back_to_back();
    test_div_zero();
    test_timeout();
    test_clear_vs_done();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
